fir_pipe: RTL
=============

FIR_PIPE -- requirements
Module: fir_pipe

Interface
REQ-001 Parameter DW, 20, input sample width in bits (signed).
REQ-002 Parameter CW, 20, coefficient width in bits (signed).
REQ-003 Parameter TAPS, 15, number of filter taps, range 2..64.
REQ-004 Parameter SHIFT, 4, arithmetic right shift applied to the accumulated sum.
REQ-005 Parameter OUT_W, 40, output width in bits (signed).
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  sample x is offered this cycle.
REQ-009 in_ready  out  1  block accepts x this cycle.
REQ-010 x  in  DW  signed input sample.
REQ-011 coef_load  in  1  load the coefficient bank from coef this cycle.
REQ-012 coef  in  TAPS*CW  signed coefficients; tap i occupies bits [i*CW +: CW]; tap 0 multiplies the newest sample.
REQ-013 out_valid  out  1  y holds a valid result.
REQ-014 out_ready  in  1  downstream accepts y this cycle.
REQ-015 y  out  OUT_W  signed filter output.

Function
REQ-016 Acceptance occurs when in_valid && in_ready; the delay line then shifts (tap i <= tap i-1, tap 0 <= x).
REQ-017 Pipeline advance adv = !(out_valid && !out_ready); in_ready = adv; on !adv every pipeline register, valid bit and the delay line holds.
REQ-018 Stage order: delay line; product register (TAPS signed DW x CW products); ceil(log2(TAPS)) registered binary adder-tree levels (odd operand passes through); output register.
REQ-019 Latency: sample accepted in cycle n, no stall -> out_valid high in cycle n+3+ceil(log2(TAPS)) (n+7 for TAPS=15).
REQ-020 One valid bit per stage travels with the data; throughput one result per cycle when out_ready stays high; no results without an accepted sample.
REQ-021 Accumulator width AW = DW+CW+ceil(log2(TAPS)); all sums are sign-extended to AW, no intermediate overflow.
REQ-022 Output value = (sum >>> SHIFT), then reduced to OUT_W per REQ-029/REQ-030, registered in the output stage.
REQ-023 coef_load writes the coefficient bank at the clock edge regardless of adv; products registered in a cycle use the bank contents present during that cycle.
REQ-024 With no stall, a sample accepted in the same cycle as coef_load, or later, uses the new coefficients; earlier samples use the old ones.
REQ-025 y and out_valid hold unchanged while out_valid && !out_ready.
REQ-026 in_valid low: delay line holds, a bubble enters the pipeline; bubbles never raise out_valid.

Reset
REQ-027 While reset is high at a clock edge: delay line, coefficient bank, all pipeline data and valid bits clear to 0; out_valid=0, y=0; in_ready=1 in the first cycle after reset.
REQ-028 Reset asserted mid-operation discards all in-flight samples; no out_valid appears for them after reset deasserts.

Configuration
REQ-029 With macro FIR_SAT_EN defined: a shifted sum above 2^(OUT_W-1)-1 yields y = 2^(OUT_W-1)-1; below -2^(OUT_W-1) yields y = -2^(OUT_W-1).
REQ-030 Without FIR_SAT_EN: y = low OUT_W bits of the shifted sum (two's-complement wrap); all other behaviour identical.

Verification
REQ-031 Defaults; coef_load with c_i=i+1; impulse x=16 then 14 zeros, out_ready=1 -> y = 1,2,...,15 on consecutive cycles, first 7 cycles after acceptance.
REQ-032 Defaults; all c_i=1, 20 accepted samples x=16 -> steady-state y=15; out_ready low 3 cycles mid-stream -> in_ready low, y held, no sample lost or duplicated.
REQ-033 Defaults; coef_load c_i=1 then c_i=2 in the same cycle as accepting sample k (constant x=16) -> outputs from sample k onward doubled, earlier outputs unchanged.
REQ-034 SHIFT=0, OUT_W=24; x=524287, all c_i=524287, 15 samples -> y=8388607 with FIR_SAT_EN; y = low 24 bits of 15*524287^2 without.
REQ-035 Reset asserted 3 cycles after accepting 5 samples -> out_valid stays 0 after deassert; next impulse x=16, c_i=i+1 -> y=1..15 again, no stale contributions.
REQ-036 x=-16, c_0=-1, others 0 -> y=1; x=-16, c_0=1 -> y=-1 (arithmetic shift sign-correct).

Source files
------------

// File: rtl/fir_pipe_if.sv
// fir_pipe_if: sample stream interface for fir_pipe.
//   in_valid / in_ready / x      : input sample handshake (master drives x)
//   out_valid / out_ready / y    : filtered result handshake (slave drives y)
// The master modport is the side that drives samples and consumes results;
// the slave modport is the filter itself.
interface fir_pipe_if #(
  parameter int DW    = 20,
  parameter int OUT_W = 40
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    x;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] y;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/fir_pipe.sv
// fir_pipe: pipelined direct-form FIR filter with valid/ready flow control.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   s          fir_pipe_if.slave stream (in_valid/in_ready/x, out_valid/out_ready/y)
//   coef_load  write the coefficient bank from coef at this clock edge
//   coef       TAPS packed signed coefficients, tap i at [i*CW +: CW];
//              tap 0 multiplies the newest sample
//
// Pipeline: delay line -> product register -> $clog2(TAPS) registered
// adder-tree levels -> output register. A valid bit travels with every stage
// and the whole pipe freezes while a result is waiting for out_ready.
//
// Build option: define FIR_SAT_EN to saturate the shifted sum into OUT_W
// bits; otherwise the low OUT_W bits are kept (two's-complement wrap).
module fir_pipe #(
  parameter int DW    = 20,
  parameter int CW    = 20,
  parameter int TAPS  = 15,
  parameter int SHIFT = 4,
  parameter int OUT_W = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_pipe_if.slave            s,
  input  logic                 coef_load,
  input  logic [TAPS*CW-1:0]   coef
);

  localparam int LV = $clog2(TAPS);
  localparam int AW = DW + CW + LV;

  // Number of operands present at adder-tree level l (level 0 = products).
  function automatic int lvl_n(input int l);
    int n;
    n = TAPS;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  logic adv;
  assign adv        = !(s.out_valid && !s.out_ready);
  assign s.in_ready = adv;

  // Delay line and its valid bit. A bubble (in_valid low) leaves the
  // samples in place but still moves an invalid slot down the pipe.
  logic signed [DW-1:0] dl [TAPS];
  logic                 dl_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
      dl_v <= 1'b0;
    end else if (adv) begin
      dl_v <= s.in_valid;
      if (s.in_valid) begin
        dl[0] <= s.x;
        for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
      end
    end
  end

  // Coefficient bank loads independently of flow control.
  logic signed [CW-1:0] cbank [TAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) cbank[i] <= '0;
    end else if (coef_load) begin
      for (int i = 0; i < TAPS; i++) cbank[i] <= coef[i*CW +: CW];
    end
  end

  // Product register (level 0) and registered binary adder tree. An odd
  // operand at the end of a level is passed through unchanged.
  for (genvar l = 0; l <= LV; l++) begin : lvl
    localparam int N = lvl_n(l);
    logic signed [AW-1:0] sum [N];

    if (l == 0) begin : g_prod
      for (genvar j = 0; j < N; j++) begin : g_mul
        always_ff @(posedge clk) begin
          if (reset)    sum[j] <= '0;
          else if (adv) sum[j] <= AW'(dl[j]) * AW'(cbank[j]);
        end
      end
    end else begin : g_add
      localparam int NP = lvl_n(l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_pair
          always_ff @(posedge clk) begin
            if (reset)    sum[j] <= '0;
            else if (adv) sum[j] <= lvl[l-1].sum[2*j] + lvl[l-1].sum[2*j+1];
          end
        end else begin : g_pass
          always_ff @(posedge clk) begin
            if (reset)    sum[j] <= '0;
            else if (adv) sum[j] <= lvl[l-1].sum[2*j];
          end
        end
      end
    end
  end

  // Valid bits: tv[0] follows the product register, tv[l] tree level l.
  logic [LV:0] tv;

  always_ff @(posedge clk) begin
    if (reset) begin
      tv <= '0;
    end else if (adv) begin
      tv[0] <= dl_v;
      for (int l = 1; l <= LV; l++) tv[l] <= tv[l-1];
    end
  end

  // Scale and reduce to the output width.
  logic signed [AW-1:0]    sh;
  logic signed [OUT_W-1:0] red;

  assign sh = lvl[LV].sum[0] >>> SHIFT;

  if (OUT_W >= AW) begin : g_ext
    assign red = OUT_W'(sh);
  end else begin : g_red
`ifdef FIR_SAT_EN
    // In range only if every bit from the OUT_W sign position upward agrees.
    logic [AW-OUT_W:0] hi;
    assign hi = sh[AW-1:OUT_W-1];

    always_comb begin
      red = sh[OUT_W-1:0];
      if (!((&hi) || !(|hi))) begin
        red = sh[AW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
`else
    assign red = sh[OUT_W-1:0];
`endif
  end

  // Output register: y only changes when a valid result moves in.
  always_ff @(posedge clk) begin
    if (reset) begin
      s.out_valid <= 1'b0;
      s.y         <= '0;
    end else if (adv) begin
      s.out_valid <= tv[LV];
      if (tv[LV]) s.y <= red;
    end
  end

endmodule
